// File: rtl/user_pb_reader.sv
// Push-button front end: reset/input synchronisers, per-button debounce, and
// press / release / long-press event pulses in the OSC_50m domain.
module user_pb_reader #(
  parameter int unsigned PB_W     = 4,
  parameter int unsigned DB_CYC   = 1000000,
  parameter int unsigned LONG_CYC = 50000000
) (
  input  logic            OSC_50m,
  input  logic            FPGA_RSTn,
  input  logic [PB_W-1:0] USER_PB,
  output logic [PB_W-1:0] pb_state,
  output logic [PB_W-1:0] pb_press,
  output logic [PB_W-1:0] pb_release,
  output logic [PB_W-1:0] pb_long
);

  localparam int unsigned DB_W = $clog2(DB_CYC);
  localparam int unsigned LP_W = $clog2(LONG_CYC);

  logic [1:0]      rst_sync;
  logic            rst_n;
  logic [PB_W-1:0] s1;
  logic [PB_W-1:0] s2;

  // Reset asserts asynchronously, releases two edges after FPGA_RSTn rises
  always_ff @(posedge OSC_50m or negedge FPGA_RSTn) begin
    if (!FPGA_RSTn) rst_sync <= 2'b00;
    else            rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  // Two-flop input synchroniser, inverted so 1 = pressed
  always_ff @(posedge OSC_50m or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= ~USER_PB;
      s2 <= s1;
    end
  end

  for (genvar i = 0; i < PB_W; i++) begin : g_bit
    logic [DB_W-1:0] db_cnt;
    logic [LP_W-1:0] lp_cnt;
    logic            lp_done;
    logic            state;
    logic            press;
    logic            rls;
    logic            lng;
    logic            flip_c;

    // Level change accepted on the DB_CYC-th consecutive differing sample
    assign flip_c = (s2[i] != state) && (db_cnt == DB_W'(DB_CYC - 1));

    always_ff @(posedge OSC_50m or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt  <= '0;
        lp_cnt  <= '0;
        lp_done <= 1'b0;
        state   <= 1'b0;
        press   <= 1'b0;
        rls     <= 1'b0;
        lng     <= 1'b0;
      end else begin
        press <= flip_c && !state;
        rls   <= flip_c && state;
        lng   <= 1'b0;

        if ((s2[i] == state) || flip_c) db_cnt <= '0;
        else                            db_cnt <= db_cnt + DB_W'(1);

        if (flip_c) state <= ~state;

        // A release accepted this cycle suppresses a coincident long press
        if (!state || flip_c) begin
          lp_cnt  <= '0;
          lp_done <= 1'b0;
        end else if (!lp_done) begin
          if (lp_cnt == LP_W'(LONG_CYC - 1)) begin
            lng     <= 1'b1;
            lp_done <= 1'b1;
          end else begin
            lp_cnt <= lp_cnt + LP_W'(1);
          end
        end
      end
    end

    assign pb_state[i]   = state;
    assign pb_press[i]   = press;
    assign pb_release[i] = rls;
    assign pb_long[i]    = lng;
  end

endmodule
